// File: rtl/lane_speed_scheduler_if.sv
// Period-write port of lane_speed_scheduler: valid/ready handshake carrying
// a target lane and a new period in base ticks.
interface lane_speed_scheduler_if #(
    parameter int unsigned PERIOD_W = 12
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [2:0]          cfg_lane;
    logic [PERIOD_W-1:0] cfg_period;

    modport master (
        output cfg_valid,
        output cfg_lane,
        output cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_lane,
        input  cfg_period,
        output cfg_ready
    );
endinterface

// File: rtl/lane_speed_scheduler.sv
// Central move-tick scheduler for the river lanes. A shared prescaler makes
// base ticks; each lane counts ticks against its own period and emits a
// registered one-cycle move strobe. Periods are written at runtime through
// the cfg port and can be shortened for all lanes by a level-up sweep.
// Build option: LANE_SCHED_LEVEL_EN enables the level-up sweep FSM, busy and
// level; without it level_up is ignored, busy/level read 0, cfg_ready is 1.
module lane_speed_scheduler #(
    parameter int unsigned     LANES          = 6,
    parameter int unsigned     PRESCALE       = 1000,
    parameter int unsigned     PERIOD_W       = 12,
    parameter int unsigned     DEFAULT_PERIOD = 200,
    parameter int unsigned     MIN_PERIOD     = 16,
    parameter int unsigned     LEVEL_STEP     = 8,
    parameter logic [LANES-1:0] DIR_MASK      = 6'b101010
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    lane_speed_scheduler_if.slave cfg,
    input  logic                  level_up,
    output logic                  busy,
    output logic [3:0]            level,
    output logic [LANES-1:0]      move_strb,
    output logic [LANES-1:0]      move_dir
);
    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [PERIOD_W-1:0] MinP  = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] DefP  = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [PERIOD_W-1:0] StepP = PERIOD_W'(LEVEL_STEP);
    // Compared one bit wider so P - LEVEL_STEP is never taken after a wrap.
    localparam logic [PERIOD_W:0]   FloorP = (PERIOD_W + 1)'(LEVEL_STEP + MIN_PERIOD);

    logic [PS_W-1:0]     presc_q, presc_d;
    logic                base_tick;
    logic [PERIOD_W-1:0] period_q [LANES];
    logic [PERIOD_W-1:0] period_d [LANES];
    logic [PERIOD_W-1:0] cnt_q    [LANES];
    logic [PERIOD_W-1:0] cnt_d    [LANES];
    logic [LANES-1:0]    strb_q, strb_d;
    logic                cfg_fire;
    logic [PERIOD_W-1:0] cfg_clamped;
    logic                sweep_en;
    logic [IDX_W-1:0]    sweep_idx;

    function automatic logic [PERIOD_W-1:0] swept_period(input logic [PERIOD_W-1:0] p);
        if (p == '0) return '0;
        if ({1'b0, p} <= FloorP) return MinP;
        return p - StepP;
    endfunction

    assign move_dir  = DIR_MASK;
    assign move_strb = strb_q;
    assign base_tick = run && (presc_q == PS_W'(PRESCALE - 1));
    assign cfg_fire  = cfg.cfg_valid && cfg.cfg_ready;

`ifdef LANE_SCHED_LEVEL_EN
    typedef enum logic [0:0] {StIdle, StScale} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       level_q, level_d;

    // Level FSM next state: one lane per SCALE cycle, level bumps on the last.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        level_d = level_q;
        case (state_q)
            StIdle: begin
                if (level_up) begin
                    state_d = StScale;
                    idx_d   = '0;
                end
            end
            StScale: begin
                if (idx_q == IDX_W'(LANES - 1)) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    if (level_q != 4'hF) level_d = level_q + 4'd1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Level FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            level_q <= level_d;
        end
    end

    assign busy          = (state_q == StScale);
    assign sweep_en      = busy;
    assign sweep_idx     = idx_q;
    assign level         = level_q;
    assign cfg.cfg_ready = (state_q == StIdle);
`else
    logic unused_level_up;
    assign unused_level_up = level_up;
    assign busy            = 1'b0;
    assign sweep_en        = 1'b0;
    assign sweep_idx       = '0;
    assign level           = 4'd0;
    assign cfg.cfg_ready   = 1'b1;
`endif

    // Clamp written periods: 0 disables, small nonzero values rise to the floor.
    always_comb begin
        cfg_clamped = cfg.cfg_period;
        if (cfg.cfg_period != '0 && cfg.cfg_period < MinP) cfg_clamped = MinP;
    end

    // Prescaler next state: frozen while paused.
    always_comb begin
        presc_d = presc_q;
        if (run) presc_d = base_tick ? '0 : presc_q + 1'b1;
    end

    // Per-lane counters, strobes and period updates; a write clears the
    // counter but a strobe already due this cycle still fires.
    always_comb begin
        strb_d = '0;
        for (int i = 0; i < LANES; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            if (period_q[i] == '0) begin
                cnt_d[i] = '0;
            end else if (base_tick) begin
                if ({1'b0, cnt_q[i]} + 1'b1 >= {1'b0, period_q[i]}) begin
                    strb_d[i] = 1'b1;
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            if (cfg_fire && (cfg.cfg_lane == 3'(i))) begin
                period_d[i] = cfg_clamped;
                cnt_d[i]    = '0;
            end
            if (sweep_en && (sweep_idx == IDX_W'(i))) begin
                period_d[i] = swept_period(period_q[i]);
            end
        end
    end

    // Prescaler, lane state and strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            strb_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                period_q[i] <= DefP;
                cnt_q[i]    <= '0;
            end
        end else begin
            presc_q <= presc_d;
            strb_q  <= strb_d;
            for (int i = 0; i < LANES; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_lane_speed_scheduler.sv
// Directed bench for lane_speed_scheduler. dut_a (MIN_PERIOD=2) covers strobe
// timing, period writes and pause; dut_b (MIN_PERIOD=16) covers clamping and
// the level-up sweep. Both use PRESCALE=4, DEFAULT_PERIOD=5, LEVEL_STEP=8.
module tb_lane_speed_scheduler;
    localparam int unsigned PW = 12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run_a, run_b, level_up_a, level_up_b;
    logic       busy_a, busy_b;
    logic [3:0] level_a, level_b;
    logic [5:0] strb_a, strb_b, dir_a, dir_b;
    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;

    lane_speed_scheduler_if #(.PERIOD_W(PW)) if_a ();
    lane_speed_scheduler_if #(.PERIOD_W(PW)) if_b ();

    lane_speed_scheduler #(
        .LANES(6), .PRESCALE(4), .PERIOD_W(PW), .DEFAULT_PERIOD(5),
        .MIN_PERIOD(2), .LEVEL_STEP(8), .DIR_MASK(6'b101010)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .run(run_a), .cfg(if_a),
        .level_up(level_up_a), .busy(busy_a), .level(level_a),
        .move_strb(strb_a), .move_dir(dir_a)
    );

    lane_speed_scheduler #(
        .LANES(6), .PRESCALE(4), .PERIOD_W(PW), .DEFAULT_PERIOD(5),
        .MIN_PERIOD(16), .LEVEL_STEP(8), .DIR_MASK(6'b101010)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .run(run_b), .cfg(if_b),
        .level_up(level_up_b), .busy(busy_b), .level(level_b),
        .move_strb(strb_b), .move_dir(dir_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    task automatic goto(input int c);
        step(c - cyc);
    endtask

    task automatic wr_a(input logic [2:0] lane, input logic [PW-1:0] p);
        if_a.cfg_lane   = lane;
        if_a.cfg_period = p;
        if_a.cfg_valid  = 1'b1;
        step(1);
        if_a.cfg_valid  = 1'b0;
    endtask

    task automatic wr_b(input logic [2:0] lane, input logic [PW-1:0] p);
        if_b.cfg_lane   = lane;
        if_b.cfg_period = p;
        if_b.cfg_valid  = 1'b1;
        step(1);
        if_b.cfg_valid  = 1'b0;
    endtask

    task automatic chk_periods_b(input string tag, input int e0, input int e1, input int e2,
                                 input int e3, input int e4, input int e5);
        int exp_p [6];
        exp_p = '{e0, e1, e2, e3, e4, e5};
        for (int i = 0; i < 6; i++) chk(tag, 32'(dut_b.period_q[i]), exp_p[i]);
    endtask

    initial begin
        reset_n         = 1'b0;
        run_a           = 1'b1;
        run_b           = 1'b0;
        level_up_a      = 1'b0;
        level_up_b      = 1'b0;
        if_a.cfg_valid  = 1'b0;
        if_a.cfg_lane   = '0;
        if_a.cfg_period = '0;
        if_b.cfg_valid  = 1'b0;
        if_b.cfg_lane   = '0;
        if_b.cfg_period = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_strb", 32'(strb_a), 0);
        chk("rst_level", 32'(level_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_ready", 32'(if_a.cfg_ready), 1);
        chk("rst_dir", 32'(dir_a), 32'h2A);
        chk("rst_ready_b", 32'(if_b.cfg_ready), 1);
        reset_n = 1'b1;
        cyc     = 0;

        // Default period 5 x prescale 4: all lanes at 20, 40, 60, single-cycle
        goto(19); chk("def_c19", 32'(strb_a), 0);
        goto(20); chk("def_c20", 32'(strb_a), 32'h3F);
        goto(21); chk("def_c21", 32'(strb_a), 0);
        goto(40); chk("def_c40", 32'(strb_a), 32'h3F);
        goto(59); chk("def_c59", 32'(strb_a), 0);
        goto(60); chk("def_c60", 32'(strb_a), 32'h3F);
        chk("dir_run", 32'(dir_a), 32'h2A);

        // Lane 2 period 3 -> strobes every 12 cycles, others unchanged
        wr_a(3'd2, 12'd3);
        goto(72);  chk("p3_c72", 32'(strb_a), 32'h04);
        goto(80);  chk("p3_c80", 32'(strb_a), 32'h3B);
        goto(84);  chk("p3_c84", 32'(strb_a), 32'h04);
        goto(96);  chk("p3_c96", 32'(strb_a), 32'h04);
        goto(100); chk("p3_c100", 32'(strb_a), 32'h3B);

        // Period 1 clamps to MIN_PERIOD=2
        wr_a(3'd2, 12'd1);
        chk("p1_stored", 32'(dut_a.period_q[2]), 2);
        goto(104); chk("p1_c104", 32'(strb_a), 0);
        goto(108); chk("p1_c108", 32'(strb_a), 32'h04);
        goto(116); chk("p1_c116", 32'(strb_a), 32'h04);
        goto(120); chk("p1_c120", 32'(strb_a), 32'h3B);
        goto(124); chk("p1_c124", 32'(strb_a), 32'h04);

        // Period 0 silences lane 2
        wr_a(3'd2, 12'd0);
        goto(132); chk("p0_c132", 32'(strb_a), 0);
        goto(140); chk("p0_c140", 32'(strb_a), 32'h3B);

        // Out-of-range lane write is discarded
        wr_a(3'd7, 12'd3);
        goto(152); chk("lane7_c152", 32'(strb_a), 0);
        goto(160); chk("lane7_c160", 32'(strb_a), 32'h3B);

        // Pause 50 cycles mid-period: strobe due at 180 moves to 230
        goto(170);
        run_a = 1'b0;
        for (int k = 0; k < 50; k++) begin
            chk("pause_quiet", 32'(strb_a), 0);
            step(1);
        end
        run_a = 1'b1;
        goto(180); chk("pause_c180", 32'(strb_a), 0);
        goto(229); chk("pause_c229", 32'(strb_a), 0);
        goto(230); chk("pause_c230", 32'(strb_a), 32'h3B);

        // dut_b: clamp to 16 and load sweep pattern
        chk("b_ready", 32'(if_b.cfg_ready), 1);
        wr_b(3'd1, 12'd5);
        chk("b_clamp16", 32'(dut_b.period_q[1]), 16);
        wr_b(3'd0, 12'd40);
        wr_b(3'd1, 12'd20);
        wr_b(3'd2, 12'd0);
        wr_b(3'd3, 12'd24);
        wr_b(3'd4, 12'd100);
        wr_b(3'd5, 12'd17);
        chk_periods_b("b_load", 40, 20, 0, 24, 100, 17);

`ifdef LANE_SCHED_LEVEL_EN
        // Sweep: busy 6 cycles, ready low, second level_up dropped
        level_up_b = 1'b1;
        step(1);
        level_up_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("sw_busy", 32'(busy_b), 1);
            chk("sw_ready", 32'(if_b.cfg_ready), 0);
            chk("sw_level_hold", 32'(level_b), 0);
            level_up_b = (k == 2);
            step(1);
        end
        level_up_b = 1'b0;
        chk("sw_done_busy", 32'(busy_b), 0);
        chk("sw_done_ready", 32'(if_b.cfg_ready), 1);
        chk("sw_level1", 32'(level_b), 1);
        step(3);
        chk("sw_drop_busy", 32'(busy_b), 0);
        chk("sw_drop_level", 32'(level_b), 1);
        chk_periods_b("sw_periods", 32, 16, 0, 16, 92, 16);

        // Write and level_up together: write first, then sweep
        if_b.cfg_lane   = 3'd0;
        if_b.cfg_period = 12'd40;
        if_b.cfg_valid  = 1'b1;
        level_up_b      = 1'b1;
        step(1);
        if_b.cfg_valid  = 1'b0;
        level_up_b      = 1'b0;
        chk("sim_written", 32'(dut_b.period_q[0]), 40);
        chk("sim_busy", 32'(busy_b), 1);
        step(6);
        chk("sim_done_busy", 32'(busy_b), 0);
        chk("sim_level2", 32'(level_b), 2);
        chk_periods_b("sim_periods", 32, 16, 0, 16, 84, 16);

        // Reset during SCALE idx=3
        level_up_b = 1'b1;
        step(1);
        level_up_b = 1'b0;
        step(3);
        chk("mid_busy", 32'(busy_b), 1);
        chk("mid_level", 32'(level_b), 2);
        reset_n = 1'b0;
        #1;
        chk("rs_busy", 32'(busy_b), 0);
        chk("rs_level", 32'(level_b), 0);
        chk("rs_ready", 32'(if_b.cfg_ready), 1);
        chk("rs_strb", 32'(strb_a), 0);
        chk_periods_b("rs_periods", 5, 5, 5, 5, 5, 5);
`else
        // Level feature absent: level_up ignored, outputs constant
        level_up_b = 1'b1;
        step(1);
        level_up_b = 1'b0;
        chk("nolvl_busy", 32'(busy_b), 0);
        chk("nolvl_ready", 32'(if_b.cfg_ready), 1);
        step(6);
        chk("nolvl_level", 32'(level_b), 0);
        chk_periods_b("nolvl_periods", 40, 20, 0, 24, 100, 17);

        if_b.cfg_lane   = 3'd0;
        if_b.cfg_period = 12'd33;
        if_b.cfg_valid  = 1'b1;
        level_up_b      = 1'b1;
        step(1);
        if_b.cfg_valid  = 1'b0;
        level_up_b      = 1'b0;
        chk("nolvl_write", 32'(dut_b.period_q[0]), 33);
        chk("nolvl_busy2", 32'(busy_b), 0);

        reset_n = 1'b0;
        #1;
        chk("rs_level", 32'(level_b), 0);
        chk("rs_strb", 32'(strb_a), 0);
        chk_periods_b("rs_periods", 5, 5, 5, 5, 5, 5);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/lane_speed_scheduler.md
# lane_speed_scheduler

Central move-tick scheduler for the six river lanes. Generates one-cycle per-lane move strobes from a shared prescaler and per-lane period registers, replacing free-running per-lane dividers. Accepts runtime period writes from the game controller over a valid/ready port. Applies a level-up speed ramp across all lanes; the log position datapath steps each lane's logs by one pixel per strobe in `move_dir`.

## Interface
- `LANES`, 6, number of lanes scheduled.
- `PRESCALE`, 1000, clk cycles per base tick.
- `PERIOD_W`, 12, period register width, in base ticks.
- `DEFAULT_PERIOD`, 200, reset value of every lane period.
- `MIN_PERIOD`, 16, floor for nonzero periods.
- `LEVEL_STEP`, 8, period decrement per level-up.
- `DIR_MASK`, 6'b101010, per-lane direction: 1 = rightward, 0 = leftward.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  1 = scheduling enabled; 0 = frozen (pause).
- `cfg_valid`  in  1  period write request.
- `cfg_ready`  out  1  write accepted when `cfg_valid & cfg_ready`.
- `cfg_lane`  in  3  target lane; values ≥ LANES are accepted and discarded.
- `cfg_period`  in  PERIOD_W  new period; 0 disables the lane.
- `level_up`  in  1  single-cycle request to speed up all lanes.
- `busy`  out  1  level-up sweep in progress.
- `level`  out  4  level count, saturating at 15.
- `move_strb`  out  LANES  one-cycle move pulse per lane.
- `move_dir`  out  LANES  constant `DIR_MASK`.

## Operation
**Prescaler**
- Counts 0..PRESCALE-1 while `run`=1.
- `base_tick` is high combinationally when count = PRESCALE-1; count then wraps to 0.

**Lane counters**
- On `base_tick` with period P ≠ 0:
  - if cnt+1 ≥ P: `move_strb[i]` <= 1 and cnt <= 0;
  - otherwise cnt increments.
- P = 0: the lane never strobes and its counter holds 0.

**Period write**
- On handshake, period[cfg_lane] <= `cfg_period`, clamped as follows:
  - 0 stays 0;
  - 1..MIN_PERIOD-1 becomes MIN_PERIOD.
- The handshake also clears that lane's counter.
- A strobe due in the same cycle still fires.

**Level FSM (two states)**
- IDLE: `level_up`=1 → SCALE, idx=0, `busy`=1.
- SCALE: one lane per cycle, idx 0..LANES-1.
  - Nonzero period becomes max(P-LEVEL_STEP, MIN_PERIOD).
  - Zero stays zero.
  - Lane counters are untouched.
  - After idx = LANES-1, return to IDLE and `level` <= sat(level+1).
- A sweep lasts exactly LANES cycles.

**Arbitration and boundaries**
- `cfg_ready` = 1 in IDLE, 0 in SCALE.
- `cfg_valid` and `level_up` in the same IDLE cycle: write accepted that cycle, sweep starts next cycle.
- `level_up` while busy: dropped.
- `run`=0 freezes the prescaler and lane counters and forces `move_strb`=0. Period writes and sweeps still proceed.
- All arithmetic is unsigned, PERIOD_W bits. Subtraction is compared before wrap (P ≤ LEVEL_STEP+MIN_PERIOD → MIN_PERIOD).

**Reset values (asynchronous, on `reset_n`=0, any state)**
- Prescaler 0, lane counters 0, periods DEFAULT_PERIOD.
- `move_strb` 0, `level` 0, `busy` 0, FSM IDLE.
- `cfg_ready` 1 after reset.

## Timing
- `move_strb` is registered: asserted the cycle after the qualifying `base_tick`.
- With continuous `run` from the first cycle after reset release (cycle 0), lane i strobes first at cycle P·PRESCALE, then every P·PRESCALE cycles.
- A period write takes effect at the next `base_tick`. The first strobe comes P ticks after the write.
- Sweep: lane k's new period is valid from cycle k+1 after `level_up`. `busy` is high for LANES cycles; `level` updates on the last one.
- `move_dir` has zero latency (constant).

## Configuration
- `LANE_SCHED_LEVEL_EN`
  - Defined: level FSM, `busy`, and `level` behave as above.
  - Undefined: FSM not built; `level_up` ignored; `busy`=0 and `level`=0 constant; `cfg_ready`=1 constant.

## Test plan
Bench parameters: PRESCALE=4, DEFAULT_PERIOD=5, MIN_PERIOD=16 except where noted, LEVEL_STEP=8.
- **Reset/default:** reset released, `run`=1, MIN_PERIOD=2 → every lane strobes at cycles 20, 40, 60; strobes are single-cycle; `move_dir`=6'b101010.
- **Config write:** MIN_PERIOD=2; write lane 2 period 3 → lane 2 strobes every 12 cycles, other lanes unchanged. Write period 1 → stored 2. Write period 0 → lane 2 silent. Write with `cfg_lane`=7 → no lane change.
- **Level sweep:** periods {40,20,0,24,100,17}, `level_up` pulse → `busy` high 6 cycles, `cfg_ready` low throughout, periods {32,16,0,16,92,16}, `level`=1. Second `level_up` during busy is dropped.
- **Simultaneous events:** `cfg_valid` (lane 0, 40) and `level_up` in the same cycle → write accepted, then sweep → lane 0 period 32.
- **Pause:** `run`=0 for 50 cycles midway through a period → no strobes while paused; after resume, the next strobe is delayed by exactly 50 cycles.
- **Reset mid-sweep:** `reset_n` low during SCALE idx=3 → immediate return to reset values; all periods DEFAULT_PERIOD, `level`=0, `busy`=0.
